// File: rtl/inner_loop_pkg.sv
// Shared constants, FSM encoding and sizing helpers for the carry-save
// inner-loop digit multiplier and the outer loop that drives it.
package inner_loop_pkg;

  localparam int DEF_SIZE  = 3072;
  localparam int DEF_RADIX = 108;
  localparam int DEF_LANES = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

  // Index width that never collapses to zero bits for tiny counts.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/digit_mul_lane.sv
// One RADIX x RADIX multiplier lane: registers the full product together
// with the digit index it belongs to and a valid flag.
module digit_mul_lane #(
  parameter int RADIX = 108,
  parameter int DW    = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               dig_ok,
  input  logic [RADIX-1:0]   a_dig,
  input  logic [RADIX-1:0]   bi,
  input  logic [DW-1:0]      dig_in,
  output logic [2*RADIX-1:0] prod,
  output logic [DW-1:0]      dig_out,
  output logic               vld
);

  localparam int PW = 2 * RADIX;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prod    <= '0;
      dig_out <= '0;
      vld     <= 1'b0;
    end else begin
      vld <= en & dig_ok;
      if (en) begin
        prod    <= PW'(a_dig) * PW'(bi);
        dig_out <= dig_in;
      end
    end
  end

endmodule

// File: rtl/inner_loop_param.sv
// Carry-save a x bi for one inner-loop step: LANES digit multipliers are
// time-multiplexed over PASSES cycles; r0 + r1 == a * bi once out_valid is set.
module inner_loop_param
  import inner_loop_pkg::*;
#(
  parameter int SIZE  = DEF_SIZE,
  parameter int RADIX = DEF_RADIX,
  parameter int LANES = DEF_LANES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SIZE+1:0]       a,
  input  logic [RADIX-1:0]      bi,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SIZE+RADIX+1:0] r0,
  output logic [SIZE+RADIX+1:0] r1,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  localparam int AW     = SIZE + 2;
  localparam int NDIG   = ceil_div(AW, RADIX);
  localparam int PASSES = ceil_div(NDIG, LANES);
  localparam int OUTW   = SIZE + RADIX + 2;
  localparam int DW     = idx_w(NDIG);
  localparam int PCW    = idx_w(PASSES);
  localparam int TAILH  = OUTW - NDIG * RADIX;  // r1 bits kept from the tail digit's high half

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. in_ready is only high in IDLE; out_valid rises one cycle after
  // DONE is entered and holds r0/r1 stable until out_ready is seen with it.
  state_t                  state;
  logic [PCW-1:0]          pass;
  logic [AW-1:0]           a_reg;
  logic [RADIX-1:0]        bi_reg;
  logic [NDIG*RADIX-1:0]   a_ext;
  logic [NDIG*RADIX-1:0]   r0_q;
  logic [OUTW-1:0]         r1_q;
  logic                    issue_en;
  logic [2*RADIX-1:0]      prod [LANES];
  logic [DW-1:0]           dig  [LANES];
  logic [LANES-1:0]        vld;

  assign issue_en  = (state == ST_ISSUE);
  assign dbg_state = state;
  assign r0        = {{TAILH{1'b0}}, r0_q};
  assign r1        = r1_q;

  always_comb begin
    a_ext          = '0;
    a_ext[AW-1:0]  = a_reg;
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    int               di;
    logic             ok;
    logic [RADIX-1:0] a_dig;

    always_comb begin
      di    = int'(pass) * LANES + l;
      ok    = (di < NDIG);
      a_dig = ok ? a_ext[di*RADIX +: RADIX] : '0;
    end

    digit_mul_lane #(.RADIX(RADIX), .DW(DW)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (issue_en),
      .dig_ok  (ok),
      .a_dig   (a_dig),
      .bi      (bi_reg),
      .dig_in  (DW'(di)),
      .prod    (prod[l]),
      .dig_out (dig[l]),
      .vld     (vld[l])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pass      <= '0;
      a_reg     <= '0;
      bi_reg    <= '0;
      r0_q      <= '0;
      r1_q      <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      for (int l = 0; l < LANES; l++) begin
        if (vld[l]) begin
          r0_q[dig[l]*RADIX +: RADIX] <= prod[l][RADIX-1:0];
          // The tail digit's high half spills past OUTW; those bits are always zero.
          if (int'(dig[l]) == NDIG - 1)
            r1_q[OUTW-1 -: TAILH] <= prod[l][RADIX +: TAILH];
          else
            r1_q[(dig[l]+1)*RADIX +: RADIX] <= prod[l][2*RADIX-1:RADIX];
        end
      end

      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_reg    <= a;
            bi_reg   <= bi;
            r0_q     <= '0;
            r1_q     <= '0;
            pass     <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          pass <= pass + 1'b1;
          if (pass == PCW'(PASSES - 1)) state <= ST_DRAIN;
        end
        ST_DRAIN: state <= ST_DONE;
        ST_DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inner_loop_param.sv
// Bench for inner_loop_param: a small 22/8/2 instance with a vector table and
// corner sequences, plus a default-size instance checked against a wide model.
module tb_inner_loop_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Small configuration: SIZE=22, RADIX=8, LANES=2
  logic        s_rst_n, s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_busy;
  logic [23:0] s_a;
  logic [7:0]  s_bi;
  logic [31:0] s_r0, s_r1;
  logic [1:0]  s_dbg;

  inner_loop_param #(.SIZE(22), .RADIX(8), .LANES(2)) u_small (
    .clk(clk), .rst_n(s_rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .a(s_a), .bi(s_bi), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .r0(s_r0), .r1(s_r1), .busy(s_busy), .dbg_state(s_dbg)
  );

  // Default configuration: SIZE=3072, RADIX=108, LANES=15
  logic          b_rst_n, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [3073:0] b_a;
  logic [107:0]  b_bi;
  logic [3181:0] b_r0, b_r1;
  logic [1:0]    b_dbg;

  inner_loop_param u_big (
    .clk(clk), .rst_n(b_rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .a(b_a), .bi(b_bi), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .r0(b_r0), .r1(b_r1), .busy(b_busy), .dbg_state(b_dbg)
  );

  typedef struct {
    logic [23:0] a;
    logic [7:0]  bi;
    logic [31:0] r0;
    logic [31:0] r1;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one op on the small instance; operands and in_valid churn after accept.
  task automatic s_run(input logic [23:0] a, input logic [7:0] bi, output int lat);
    @(negedge clk);
    s_in_valid = 1'b1;
    s_a        = a;
    s_bi       = bi;
    @(posedge clk);
    #1;
    s_in_valid = 1'b0;
    lat = 0;
    while (!s_out_valid && lat < 20) begin
      @(negedge clk);
      s_a        = 24'($urandom);
      s_bi       = 8'($urandom);
      s_in_valid = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      lat++;
    end
    s_in_valid = 1'b0;
  endtask

  task automatic s_release();
    @(negedge clk);
    s_out_ready = 1'b1;
    @(posedge clk);
    #1;
    s_out_ready = 1'b0;
    chk("s_rel_in_ready", 64'(s_in_ready), 64'd1);
    chk("s_rel_out_valid", 64'(s_out_valid), 64'd0);
  endtask

  task automatic s_vec(input string tag, input vec_t v);
    int lat;
    s_run(v.a, v.bi, lat);
    chk({tag, "_lat"}, 64'(lat), 64'd4);
    chk({tag, "_r0"}, 64'(s_r0), 64'(v.r0));
    chk({tag, "_r1"}, 64'(s_r1), 64'(v.r1));
    chk({tag, "_sum"}, 64'(s_r0 + s_r1), 64'(32'(v.a) * 32'(v.bi)));
    s_release();
  endtask

  task automatic b_run(input logic [3073:0] a, input logic [107:0] bi);
    logic [3181:0] prod, sum;
    logic [157:0]  tp;
    int            lat;
    @(negedge clk);
    b_in_valid = 1'b1;
    b_a        = a;
    b_bi       = bi;
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    lat = 0;
    while (!b_out_valid && lat < 20) begin
      @(negedge clk);
      b_a  = ~b_a;
      b_bi = ~b_bi;
      @(posedge clk);
      #1;
      lat++;
    end
    prod = 3182'(a) * 3182'(bi);
    sum  = b_r0 + b_r1;
    tp   = 158'(a[3073:3024]) * 158'(bi);
    chk("b_lat", 64'(lat), 64'd4);
    checks++;
    if (sum !== prod) begin
      failures++;
      $display("FAIL b_sum: got low 0x%h expected low 0x%h", sum[63:0], prod[63:0]);
    end
    chk("b_tail", 64'(b_r1[3181:3132]), 64'(tp[157:108]));
    chk("b_zero_bits", {62'd0, |b_r1[107:0], |b_r0[3181:3132]}, 64'd0);
    @(negedge clk);
    b_out_ready = 1'b1;
    @(posedge clk);
    #1;
    b_out_ready = 1'b0;
  endtask

  initial begin
    int            lat;
    logic [31:0]   hold_r0, hold_r1;
    logic [3103:0] w;
    logic [3073:0] ra;

    vecs[0] = '{a: 24'h000001, bi: 8'h01, r0: 32'h00000001, r1: 32'h00000000};
    vecs[1] = '{a: 24'hFFFFFF, bi: 8'hFF, r0: 32'h00010101, r1: 32'hFEFEFE00};
    vecs[2] = '{a: 24'h000000, bi: 8'h5A, r0: 32'h00000000, r1: 32'h00000000};
    vecs[3] = '{a: 24'h123456, bi: 8'h00, r0: 32'h00000000, r1: 32'h00000000};
    vecs[4] = '{a: 24'h010203, bi: 8'h02, r0: 32'h00020406, r1: 32'h00000000};
    vecs[5] = '{a: 24'h80FF10, bi: 8'h10, r0: 32'h0000F000, r1: 32'h080F0100};
    vecs[6] = '{a: 24'hABCDEF, bi: 8'h01, r0: 32'h00ABCDEF, r1: 32'h00000000};

    // Clock/reset
    s_rst_n = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b0; s_a = '0; s_bi = '0;
    b_rst_n = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_a = '0; b_bi = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    s_rst_n = 1'b1;
    b_rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(s_in_ready), 64'd1);
    chk("rst_flags", {61'd0, s_out_valid, s_busy, 1'b0}, 64'd0);
    chk("rst_r0", 64'(s_r0), 64'd0);
    chk("rst_r1", 64'(s_r1), 64'd0);
    chk("rst_state", 64'(s_dbg), 64'd0);
    chk("rst_big", {61'd0, b_in_ready, b_out_valid, b_busy}, 64'd4);

    // Table-driven vectors
    for (int i = 0; i < 7; i++) s_vec($sformatf("vec%0d", i), vecs[i]);

    // Backpressure: result held, new requests ignored
    s_run(24'hFFFFFF, 8'hFF, lat);
    chk("bp_lat", 64'(lat), 64'd4);
    hold_r0 = 32'h00010101;
    hold_r1 = 32'hFEFEFE00;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      s_in_valid = 1'b1;
      s_a        = 24'($urandom);
      s_bi       = 8'($urandom);
      @(posedge clk);
      #1;
      chk("bp_flags", {61'd0, s_out_valid, s_in_ready, s_busy}, 64'd5);
      chk("bp_r0", 64'(s_r0), 64'(hold_r0));
      chk("bp_r1", 64'(s_r1), 64'(hold_r1));
    end
    s_in_valid = 1'b0;
    s_release();
    s_vec("bp_next", vecs[4]);

    // Reset during ISSUE pass 1
    @(negedge clk);
    s_in_valid = 1'b1;
    s_a        = 24'hFFFFFF;
    s_bi       = 8'hFF;
    @(posedge clk);
    #1;
    s_in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_state_issue", 64'(s_dbg), 64'd1);
    @(negedge clk);
    s_rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_r0", 64'(s_r0), 64'd0);
    chk("mid_rst_r1", 64'(s_r1), 64'd0);
    chk("mid_rst_flags", {61'd0, s_out_valid, s_in_ready, s_busy}, 64'd2);
    @(negedge clk);
    s_rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("mid_no_valid", 64'(s_out_valid), 64'd0);
    end
    s_vec("after_rst", '{a: 24'd5, bi: 8'd3, r0: 32'd15, r1: 32'd0});

    // Default-size instance: corners then random operands
    b_run('1, '1);
    b_run('0, '1);
    b_run('1, '0);
    b_run(3074'd1, 108'd1);
    for (int n = 0; n < 1000; n++) begin
      for (int k = 0; k < 97; k++) w[k*32 +: 32] = $urandom;
      ra = w[3073:0];
      b_run(ra, {w[3103:3074], w[77:0]} ^ {$urandom, $urandom, $urandom, 12'($urandom)});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
